// File: rtl/wb_arbiter.sv
// Write-back arbiter: three requesters (pipe, lsu, mdu) share one registered register-file write port.
// Optional starvation promotion is enabled by defining WB_ARB_STARVE_EN.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_valid,
  input  logic        lsu_valid,
  input  logic        mdu_valid,
  output logic        pipe_ready,
  output logic        lsu_ready,
  output logic        mdu_ready,
  input  logic [4:0]  pipe_rd,
  input  logic [4:0]  lsu_rd,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] pipe_data,
  input  logic [31:0] lsu_data,
  input  logic [31:0] mdu_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [15:0] stall_cnt,
  input  logic        stall_clr
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("wb_arbiter: STARVE_LIMIT must lie in 1..15");
  end

  // Bit index is the requester number: 0 = pipe, 1 = lsu, 2 = mdu.
  logic [2:0]  valid;
  logic [2:0]  grant;
  logic        handshake;
  logic        deny;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;

  assign valid = {mdu_valid, lsu_valid, pipe_valid};

`ifdef WB_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt [3];
  logic [2:0] starved;

  always_comb begin
    starved = '0;
    for (int unsigned i = 0; i < 3; i++)
      starved[i] = valid[i] && (starve_cnt[i] >= LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) starve_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (!valid[i] || grant[i])
          starve_cnt[i] <= '0;
        else if (starve_cnt[i] != 4'hF)
          starve_cnt[i] <= starve_cnt[i] + 4'd1;
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (lsu_valid)       grant = 3'b010;
    else if (pipe_valid) grant = 3'b001;
    else if (mdu_valid)  grant = 3'b100;
`ifdef WB_ARB_STARVE_EN
    // Isolate the lowest starved index so it overrides base priority.
    if (|starved) grant = starved & (~starved + 3'd1);
`endif
    if (!rst_n) grant = '0;
  end

  assign pipe_ready = grant[0];
  assign lsu_ready  = grant[1];
  assign mdu_ready  = grant[2];
  assign handshake  = |grant;
  assign deny       = |(valid & ~grant);

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    unique case (1'b1)
      grant[0]: begin sel_rd = pipe_rd; sel_data = pipe_data; end
      grant[1]: begin sel_rd = lsu_rd;  sel_data = lsu_data;  end
      grant[2]: begin sel_rd = mdu_rd;  sel_data = mdu_data;  end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= handshake && (sel_rd != '0);
      if (handshake && (sel_rd != '0)) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_clr)
      stall_cnt <= '0;
    else if (deny && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; the starvation scenario follows WB_ARB_STARVE_EN.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_valid, lsu_valid, mdu_valid;
  logic        pipe_ready, lsu_ready, mdu_ready;
  logic [4:0]  pipe_rd, lsu_rd, mdu_rd;
  logic [31:0] pipe_data, lsu_data, mdu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] stall_cnt;
  logic        stall_clr;

  int unsigned compared;
  int unsigned mismatched;

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_valid(pipe_valid), .lsu_valid(lsu_valid), .mdu_valid(mdu_valid),
    .pipe_ready(pipe_ready), .lsu_ready(lsu_ready), .mdu_ready(mdu_ready),
    .pipe_rd(pipe_rd), .lsu_rd(lsu_rd), .mdu_rd(mdu_rd),
    .pipe_data(pipe_data), .lsu_data(lsu_data), .mdu_data(mdu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    stall_clr  = 1'b0;
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    mdu_valid  = 1'b0; mdu_rd  = '0; mdu_data  = '0;
    lsu_valid  = 1'b1; lsu_rd  = 5'd5; lsu_data = 32'h0000_0055;

    // Reset state with a request already pending
    #12;
    chk("rst_we",     32'(rf_we),     32'd0);
    chk("rst_waddr",  32'(rf_waddr),  32'd0);
    chk("rst_wdata",  rf_wdata,       32'd0);
    chk("rst_stall",  32'(stall_cnt), 32'd0);
    chk("rst_lsu_rdy",32'(lsu_ready), 32'd0);

    // Release, see the grant, then reassert reset before the edge
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("pre_rst_lsu_rdy", 32'(lsu_ready), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_we",      32'(rf_we),     32'd0);
    chk("midrst_lsu_rdy", 32'(lsu_ready), 32'd0);
    lsu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("postrst_we",    32'(rf_we),     32'd0);
    chk("postrst_waddr", 32'(rf_waddr),  32'd0);
    chk("postrst_stall", 32'(stall_cnt), 32'd0);

    // Lone pipe request
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h0000_1004;
    #1;
    chk("single_pipe_rdy", 32'(pipe_ready), 32'd1);
    chk("single_lsu_rdy",  32'(lsu_ready),  32'd0);
    tick();
    pipe_valid = 1'b0;
    chk("single_we",    32'(rf_we),    32'd1);
    chk("single_waddr", 32'(rf_waddr), 32'd3);
    chk("single_wdata", rf_wdata,      32'h0000_1004);

    // lsu and pipe collide
    lsu_valid  = 1'b1; lsu_rd  = 5'd7; lsu_data  = 32'hDEAD_BEEF;
    pipe_valid = 1'b1; pipe_rd = 5'd8; pipe_data = 32'h0000_0011;
    #1;
    chk("coll_lsu_rdy",  32'(lsu_ready),  32'd1);
    chk("coll_pipe_rdy", 32'(pipe_ready), 32'd0);
    tick();
    lsu_valid = 1'b0;
    chk("coll_we1",    32'(rf_we),     32'd1);
    chk("coll_waddr1", 32'(rf_waddr),  32'd7);
    chk("coll_wdata1", rf_wdata,       32'hDEAD_BEEF);
    chk("coll_stall",  32'(stall_cnt), 32'd1);
    #1;
    chk("coll_pipe_rdy2", 32'(pipe_ready), 32'd1);
    tick();
    pipe_valid = 1'b0;
    chk("coll_we2",    32'(rf_we),     32'd1);
    chk("coll_waddr2", 32'(rf_waddr),  32'd8);
    chk("coll_wdata2", rf_wdata,       32'h0000_0011);
    chk("coll_stall2", 32'(stall_cnt), 32'd1);
    tick();
    chk("idle_we",    32'(rf_we),    32'd0);
    chk("idle_waddr", 32'(rf_waddr), 32'd8);

    // Write to x0 is accepted but suppressed
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'hFFFF_FFFF;
    #1;
    chk("x0_mdu_rdy", 32'(mdu_ready), 32'd1);
    tick();
    mdu_valid = 1'b0;
    chk("x0_we",    32'(rf_we),    32'd0);
    chk("x0_waddr", 32'(rf_waddr), 32'd8);
    chk("x0_wdata", rf_wdata,      32'h0000_0011);

    lsu_rd = 5'd9; lsu_data = 32'h0000_0099; mdu_rd = 5'd12; mdu_data = 32'h0000_00CC;
`ifdef WB_ARB_STARVE_EN
    // lsu and mdu contend: mdu denied in cycles 0..3, promoted in cycle 4
    lsu_valid = 1'b1; mdu_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("starve_mdu_rdy_c%0d", c), 32'(mdu_ready), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_lsu_rdy_c%0d", c), 32'(lsu_ready), (c == 4) ? 32'd0 : 32'd1);
      tick();
    end
    lsu_valid = 1'b0; mdu_valid = 1'b0;
    chk("starve_waddr", 32'(rf_waddr),  32'd12);
    chk("starve_stall", 32'(stall_cnt), 32'd6);
`else
    // Fixed priority: mdu never wins against lsu/pipe
    lsu_valid = 1'b1; pipe_valid = 1'b1; mdu_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("fixed_mdu_rdy_c%0d", c), 32'(mdu_ready), 32'd0);
      chk($sformatf("fixed_lsu_rdy_c%0d", c), 32'(lsu_ready), 32'd1);
      tick();
    end
    lsu_valid = 1'b0; pipe_valid = 1'b0; mdu_valid = 1'b0;
    chk("fixed_stall", 32'(stall_cnt), 32'd9);
`endif

    // Clear with no contention
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("clr_idle", 32'(stall_cnt), 32'd0);

    // Saturation: 65534 contended cycles, then three more, then clear under contention
    lsu_valid = 1'b1; pipe_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(stall_cnt), 32'h0000_FFFE);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("sat_ffff_%0d", c), 32'(stall_cnt), 32'h0000_FFFF);
    end
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("sat_clr", 32'(stall_cnt), 32'd0);
    lsu_valid = 1'b0; pipe_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
